// File: rtl/ping_scheduler.sv
// ping_scheduler
// Master sequencer for one sonar ping cycle. Each ping starts with a one-cycle
// trigger pulse, which is time zero for time_of_flight. The transmit burst is gated
// next, then transmitter ring-down is blanked. A listen window follows, in which the
// raw comparator echo is debounced. The ping reports either a qualified echo or a
// timeout. Pings repeat every PING_PERIOD_CYCLES while enable_in stays high.
//
// Ports:
//   clk_in           in   system clock
//   rst_in           in   asynchronous, active-high reset
//   enable_in        in   level; 1 = keep pinging, 0 = stop after the current ping
//   echo_in          in   raw echo comparator output
//   trigger_out      out  1-cycle pulse at ping start
//   burst_active_out out  high while the transmitters are driven
//   listen_out       out  high while the listen window is open
//   echo_valid_out   out  1-cycle pulse, qualified echo this ping
//   timeout_out      out  1-cycle pulse, listen window expired with no echo
//   ping_count_out   out  pings issued since reset (wraps)
module ping_scheduler #(
  parameter int unsigned BURST_CYCLES       = 20000,
  parameter int unsigned BLANK_CYCLES       = 50000,
  parameter int unsigned LISTEN_CYCLES      = 5000000,
  parameter int unsigned PING_PERIOD_CYCLES = 6000000,
  parameter int unsigned ECHO_HOLD          = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic        echo_in,
  output logic        trigger_out,
  output logic        burst_active_out,
  output logic        listen_out,
  output logic        echo_valid_out,
  output logic        timeout_out,
  output logic [15:0] ping_count_out
);

  // The phase counter is shared by BURST, BLANK and LISTEN, so it is sized for the longest of them.
  localparam int unsigned PH_MAX = (BURST_CYCLES > BLANK_CYCLES)
                                   ? ((BURST_CYCLES > LISTEN_CYCLES) ? BURST_CYCLES : LISTEN_CYCLES)
                                   : ((BLANK_CYCLES > LISTEN_CYCLES) ? BLANK_CYCLES : LISTEN_CYCLES);
  localparam int unsigned PW  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned PRW = (PING_PERIOD_CYCLES > 1) ? $clog2(PING_PERIOD_CYCLES) : 1;
  localparam int unsigned QW  = $clog2(ECHO_HOLD + 1);

  if (PING_PERIOD_CYCLES < BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES + 2) begin : g_bad_period
    $error("ping_scheduler: PING_PERIOD_CYCLES too short for burst+blank+listen");
  end
  if (ECHO_HOLD < 1) begin : g_bad_hold
    $error("ping_scheduler: ECHO_HOLD must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_BLANK  = 3'd2,
    ST_LISTEN = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   phase_cnt_r;   // cycles spent in the current phase
  logic [PRW-1:0]  period_cnt_r;  // cycles since the last trigger edge
  logic [QW-1:0]   qual_cnt_r;    // consecutive high echo samples
  logic            start_s;
  logic            period_end_s;
  logic            listen_last_s;
  logic            echo_hit_s;

  // Decode the ping-start condition and the listen-window sample outcome.
  always_comb begin
    start_s       = 1'b0;
    period_end_s  = (period_cnt_r == PRW'(PING_PERIOD_CYCLES - 1));
    listen_last_s = (phase_cnt_r == PW'(LISTEN_CYCLES - 1));
    // A high sample that completes the hold run qualifies the echo, even on the last sample.
    echo_hit_s    = echo_in && (qual_cnt_r == QW'(ECHO_HOLD - 1));
    if (enable_in && ((state_r == ST_IDLE) || ((state_r == ST_WAIT) && period_end_s))) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Ping sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r          <= ST_IDLE;
      phase_cnt_r      <= '0;
      period_cnt_r     <= '0;
      qual_cnt_r       <= '0;
      trigger_out      <= 1'b0;
      burst_active_out <= 1'b0;
      listen_out       <= 1'b0;
      echo_valid_out   <= 1'b0;
      timeout_out      <= 1'b0;
      ping_count_out   <= 16'd0;
    end else begin
      trigger_out    <= 1'b0;
      echo_valid_out <= 1'b0;
      timeout_out    <= 1'b0;
      if (state_r != ST_IDLE) begin
        period_cnt_r <= period_cnt_r + PRW'(1);
      end

      if (start_s) begin
        // Trigger edge: time zero for this ping.
        state_r          <= ST_BURST;
        trigger_out      <= 1'b1;
        burst_active_out <= 1'b1;
        listen_out       <= 1'b0;
        ping_count_out   <= ping_count_out + 16'd1;
        period_cnt_r     <= '0;
        phase_cnt_r      <= '0;
        qual_cnt_r       <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_BURST: begin
            if (phase_cnt_r == PW'(BURST_CYCLES - 1)) begin
              state_r          <= ST_BLANK;
              burst_active_out <= 1'b0;
              phase_cnt_r      <= '0;
            end else begin
              phase_cnt_r <= phase_cnt_r + PW'(1);
            end
          end
          ST_BLANK: begin
            // echo_in is ignored while the transducers ring down.
            qual_cnt_r <= '0;
            if (phase_cnt_r == PW'(BLANK_CYCLES - 1)) begin
              state_r     <= ST_LISTEN;
              listen_out  <= 1'b1;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_cnt_r + PW'(1);
            end
          end
          ST_LISTEN: begin
            if (echo_hit_s) begin
              state_r        <= ST_WAIT;
              echo_valid_out <= 1'b1;
              listen_out     <= 1'b0;
              qual_cnt_r     <= '0;
            end else if (listen_last_s) begin
              state_r     <= ST_WAIT;
              timeout_out <= 1'b1;
              listen_out  <= 1'b0;
              qual_cnt_r  <= '0;
            end else begin
              phase_cnt_r <= phase_cnt_r + PW'(1);
              qual_cnt_r  <= echo_in ? (qual_cnt_r + QW'(1)) : '0;
            end
          end
          ST_WAIT: begin
            // A restart is taken by start_s above; only the stop case lands here.
            if (period_end_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
          default: begin
            state_r          <= ST_IDLE;
            burst_active_out <= 1'b0;
            listen_out       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ping_scheduler.sv
// Self-checking bench for ping_scheduler with small parameters. The expected
// trigger, echo and timeout events are queued when a scenario is driven. Each event
// pulse seen on the DUT pops the queue front and is compared against it. The burst
// and listen windows are checked on every cycle from the timing of each ping.
module tb_ping_scheduler;

  localparam int B = 4;
  localparam int BL = 3;
  localparam int L = 10;
  localparam int P = 30;
  localparam int H = 2;

  localparam int K_TRIG = 0;
  localparam int K_ECHO = 1;
  localparam int K_TMO = 2;

  typedef struct {
    int kind;
    int edge_idx;
    int cnt;
  } evt_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        echo_in = 1'b0;
  logic        trigger_out;
  logic        burst_active_out;
  logic        listen_out;
  logic        echo_valid_out;
  logic        timeout_out;
  logic [15:0] ping_count_out;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ping_scheduler #(
    .BURST_CYCLES(B), .BLANK_CYCLES(BL), .LISTEN_CYCLES(L),
    .PING_PERIOD_CYCLES(P), .ECHO_HOLD(H)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .echo_in(echo_in),
    .trigger_out(trigger_out), .burst_active_out(burst_active_out),
    .listen_out(listen_out), .echo_valid_out(echo_valid_out),
    .timeout_out(timeout_out), .ping_count_out(ping_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int edge_idx, input int cnt);
    evt_t ev;
    ev.kind = kind;
    ev.edge_idx = edge_idx;
    ev.cnt = cnt;
    exp_q.push_back(ev);
  endtask

  task automatic observe(input int kind, input int e);
    evt_t ev;
    if (exp_q.size() == 0) begin
      check("spurious_event_kind", kind, -1);
    end else begin
      ev = exp_q.pop_front();
      check("event_kind", kind, ev.kind);
      check("event_edge", e, ev.edge_idx);
      if (kind == K_TRIG) check("ping_count", int'(ping_count_out), ev.cnt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trigger"}, int'(trigger_out), 0);
    check({tag, "_burst"}, int'(burst_active_out), 0);
    check({tag, "_listen"}, int'(listen_out), 0);
    check({tag, "_echo_valid"}, int'(echo_valid_out), 0);
    check({tag, "_timeout"}, int'(timeout_out), 0);
    check({tag, "_count"}, int'(ping_count_out), 0);
  endtask

  // Assert reset at a falling edge, check the cleared outputs, and release it at a later falling edge.
  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    enable_in = 1'b0;
    echo_in = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Drive n edges with edge 0 as the first trigger. enable_in is 1 before drop_edge.
  // echo_in follows mask. Ping 0's listen window ends after edge lend0.
  task automatic run(input int n, input logic [63:0] mask, input int drop_edge, input int lend0);
    logic [63:0] m;
    int p;
    int r;
    int active;
    int lend;
    m = mask;
    for (int e = 0; e < n; e++) begin
      @(negedge clk_in);
      enable_in = (e < drop_edge) ? 1'b1 : 1'b0;
      echo_in = (e < 64) ? m[e] : 1'b0;
      @(posedge clk_in);
      #1;
      p = e / P;
      r = e % P;
      active = (p * P < drop_edge) ? 1 : 0;
      lend = (p == 0) ? lend0 : (B + BL + L - 1);
      if (trigger_out) observe(K_TRIG, e);
      if (echo_valid_out) observe(K_ECHO, e);
      if (timeout_out) observe(K_TMO, e);
      check("burst_active", int'(burst_active_out), (active == 1 && r <= B - 1) ? 1 : 0);
      check("listen", int'(listen_out), (active == 1 && r >= B + BL && r <= lend) ? 1 : 0);
    end
    check("events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] mask;

    do_reset();

    // Continuous pinging with no echo: three timeouts at edges 17, 47 and 77.
    push(K_TRIG, 0, 1);
    push(K_TMO, 17, 0);
    push(K_TRIG, 30, 2);
    push(K_TMO, 47, 0);
    push(K_TRIG, 60, 3);
    push(K_TMO, 77, 0);
    run(90, 64'd0, 1000, 16);
    check("count_after_three", int'(ping_count_out), 3);

    // The echo qualifies on samples 10 and 11.
    do_reset();
    mask = 64'd0;
    mask[10] = 1'b1;
    mask[11] = 1'b1;
    push(K_TRIG, 0, 1);
    push(K_ECHO, 11, 0);
    push(K_TRIG, 30, 2);
    run(31, mask, 1000, 10);

    // Echo during blanking and an isolated high at edge 9 are both discarded.
    do_reset();
    mask = 64'd0;
    for (int i = 0; i <= 6; i++) mask[i] = 1'b1;
    mask[9] = 1'b1;
    push(K_TRIG, 0, 1);
    push(K_TMO, 17, 0);
    push(K_TRIG, 30, 2);
    run(31, mask, 1000, 16);

    // Qualification on the last listen sample wins over the timeout.
    do_reset();
    mask = 64'd0;
    mask[16] = 1'b1;
    mask[17] = 1'b1;
    push(K_TRIG, 0, 1);
    push(K_ECHO, 17, 0);
    push(K_TRIG, 30, 2);
    run(31, mask, 1000, 16);

    // enable_in drops at edge 5: the ping finishes and there is no trigger at edge 30.
    do_reset();
    push(K_TRIG, 0, 1);
    push(K_TMO, 17, 0);
    run(45, 64'd0, 5, 16);
    check("count_after_stop", int'(ping_count_out), 1);

    // Reset during listen clears all outputs at once, then the DUT restarts cleanly.
    do_reset();
    push(K_TRIG, 0, 1);
    run(13, 64'd0, 1000, 16);
    check("listen_before_reset", int'(listen_out), 1);
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("midlisten_reset");
    enable_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    push(K_TRIG, 0, 1);
    push(K_TMO, 17, 0);
    push(K_TRIG, 30, 2);
    run(31, 64'd0, 1000, 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
